// File: rtl/ascon_aead128_host_seq.sv
// ascon_aead128_host_seq
//   Host-side sequencer for the ascon_aead128_core handshake. Converts a
//   byte-counted AD / data block stream into padded 128-bit core blocks,
//   frames core_start / core_valid_ad / core_valid_db_in, returns trimmed
//   output blocks and captures the tag.
// Ports
//   clk, rst                   clock, asynchronous active-high reset
//   msg_start                  begin a message (honoured in IDLE only)
//   s_valid/s_ready/s_data/s_bytes/s_is_ad/s_last   upstream block stream
//   core_start, core_valid_ad, core_valid_db_in, core_ad, core_db   to core
//   core_ready, core_valid_db_out, core_valid_tag, core_dout        from core
//   m_valid/m_data/m_bytes/m_last   output blocks (no backpressure)
//   tag_valid/tag              tag output
//   busy, err_proto, err_timeout    status (error flags are sticky)
module ascon_aead128_host_seq #(
  parameter int unsigned TIMEOUT_CYCLES = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         msg_start,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [127:0] s_data,
  input  logic [4:0]   s_bytes,
  input  logic         s_is_ad,
  input  logic         s_last,
  output logic         core_start,
  output logic         core_valid_ad,
  output logic         core_valid_db_in,
  output logic [127:0] core_ad,
  output logic [127:0] core_db,
  input  logic         core_ready,
  input  logic         core_valid_db_out,
  input  logic         core_valid_tag,
  input  logic [127:0] core_dout,
  output logic         m_valid,
  output logic [127:0] m_data,
  output logic [4:0]   m_bytes,
  output logic         m_last,
  output logic         tag_valid,
  output logic [127:0] tag,
  output logic         busy,
  output logic         err_proto,
  output logic         err_timeout
);

  typedef enum logic [2:0] {
    IDLE, INIT, FEED, PAD_AD, PAD_DB, WAIT_TAG
  } state_t;

  localparam logic [127:0] PAD_BLOCK = 128'h1;

  state_t       state;
  logic         ad_done;
  logic         core_start_q;
  logic [4:0]   meta_bytes;
  logic         meta_last;
  logic         meta_supp;
  logic [31:0]  tmo_cnt;

  logic         accept;
  logic         s_full;
  logic         ad_take;
  logic         last_strobe;
  logic         stalled;

  // Keep bytes below n, place 0x01 at byte n, zero above; n>=16 passes through.
  function automatic logic [127:0] pad_block(input logic [127:0] d, input logic [4:0] n);
    logic [127:0] r;
    r = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (i < 32'(n))       r[8*i +: 8] = d[8*i +: 8];
      else if (i == 32'(n)) r[8*i +: 8] = 8'h01;
    end
    return r;
  endfunction

  function automatic logic [127:0] trim_block(input logic [127:0] d, input logic [4:0] n);
    logic [127:0] r;
    r = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (i < 32'(n)) r[8*i +: 8] = d[8*i +: 8];
    end
    return r;
  endfunction

  always_comb begin
    s_ready          = core_ready && (state == FEED);
    accept           = s_valid && s_ready;
    s_full           = (s_bytes >= 5'd16);
    ad_take          = accept && s_is_ad && !ad_done;
    core_valid_ad    = (ad_take && (s_bytes != 5'd0)) || ((state == PAD_AD) && core_ready);
    core_valid_db_in = (accept && !s_is_ad) || ((state == PAD_DB) && core_ready);
    // core_start drops combinationally in the final data strobe's own cycle.
    last_strobe      = (accept && !s_is_ad && !s_full) || ((state == PAD_DB) && core_ready);
    core_start       = core_start_q && !last_strobe;

    core_ad = '0;
    if (state == PAD_AD)    core_ad = PAD_BLOCK;
    else if (core_valid_ad) core_ad = pad_block(s_data, s_bytes);

    core_db = '0;
    if (state == PAD_DB)       core_db = PAD_BLOCK;
    else if (core_valid_db_in) core_db = pad_block(s_data, s_bytes);

    stalled = (((state == INIT) || (state == FEED) || (state == PAD_AD) || (state == PAD_DB))
               && !core_ready)
              || ((state == WAIT_TAG) && !core_valid_tag);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      ad_done      <= 1'b0;
      core_start_q <= 1'b0;
      meta_bytes   <= '0;
      meta_last    <= 1'b0;
      meta_supp    <= 1'b0;
      tmo_cnt      <= '0;
      m_valid      <= 1'b0;
      m_data       <= '0;
      m_bytes      <= '0;
      m_last       <= 1'b0;
      tag_valid    <= 1'b0;
      tag          <= '0;
      busy         <= 1'b0;
      err_proto    <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      m_valid   <= 1'b0;
      tag_valid <= 1'b0;

      if (core_valid_db_out && !meta_supp) begin
        m_valid <= 1'b1;
        m_data  <= trim_block(core_dout, meta_bytes);
        m_bytes <= meta_bytes;
        m_last  <= meta_last;
      end

      if (core_valid_db_in) begin
        meta_bytes <= (state == PAD_DB) ? 5'd0 : s_bytes;
        meta_last  <= (state == FEED) && s_last;
        meta_supp  <= (state == PAD_DB);
      end

      tmo_cnt <= stalled ? tmo_cnt + 32'd1 : '0;

      unique case (state)
        IDLE: begin
          if (msg_start) begin
            core_start_q <= 1'b1;
            busy         <= 1'b1;
            err_proto    <= 1'b0;
            err_timeout  <= 1'b0;
            ad_done      <= 1'b0;
            state        <= INIT;
          end
        end
        INIT: begin
          if (core_ready) state <= FEED;
        end
        FEED: begin
          if (accept) begin
            if (s_is_ad && !ad_done) begin
              if (s_full) begin
                if (s_last) state <= PAD_AD;
              end else begin
                ad_done <= 1'b1;
                if (s_bytes == 5'd0 || !s_last) err_proto <= 1'b1;
              end
            end else if (s_is_ad) begin
              err_proto <= 1'b1;
            end else begin
              ad_done <= 1'b1;
              if (s_full) begin
                if (s_last) state <= PAD_DB;
              end else begin
                core_start_q <= 1'b0;
                state        <= WAIT_TAG;
                if (!s_last) err_proto <= 1'b1;
              end
            end
          end
        end
        PAD_AD: begin
          if (core_ready) begin
            ad_done <= 1'b1;
            state   <= FEED;
          end
        end
        PAD_DB: begin
          if (core_ready) begin
            core_start_q <= 1'b0;
            state        <= WAIT_TAG;
          end
        end
        WAIT_TAG: begin
          if (core_valid_tag) begin
            tag       <= core_dout;
            tag_valid <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // Abort overrides whatever the state machine chose this cycle.
      if (stalled && (tmo_cnt + 32'd1 >= TIMEOUT_CYCLES)) begin
        err_timeout  <= 1'b1;
        core_start_q <= 1'b0;
        busy         <= 1'b0;
        tmo_cnt      <= '0;
        state        <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_ascon_aead128_host_seq.sv
// Scoreboard bench for ascon_aead128_host_seq with a behavioural core model.
module tb_ascon_aead128_host_seq;

  localparam int unsigned TMO = 32;
  localparam logic [127:0] KS = {16{8'h80}};

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         msg_start = 1'b0;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [127:0] s_data = '0;
  logic [4:0]   s_bytes = '0;
  logic         s_is_ad = 1'b0;
  logic         s_last = 1'b0;
  logic         core_start, core_valid_ad, core_valid_db_in;
  logic [127:0] core_ad, core_db;
  logic         core_ready;
  logic         core_valid_db_out, core_valid_tag;
  logic [127:0] core_dout;
  logic         m_valid, m_last, tag_valid, busy, err_proto, err_timeout;
  logic [127:0] m_data, tag;
  logic [4:0]   m_bytes;

  ascon_aead128_host_seq #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .msg_start(msg_start),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_bytes(s_bytes),
    .s_is_ad(s_is_ad), .s_last(s_last),
    .core_start(core_start), .core_valid_ad(core_valid_ad),
    .core_valid_db_in(core_valid_db_in), .core_ad(core_ad), .core_db(core_db),
    .core_ready(core_ready), .core_valid_db_out(core_valid_db_out),
    .core_valid_tag(core_valid_tag), .core_dout(core_dout),
    .m_valid(m_valid), .m_data(m_data), .m_bytes(m_bytes), .m_last(m_last),
    .tag_valid(tag_valid), .tag(tag), .busy(busy),
    .err_proto(err_proto), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  // Core model: busy 2 cycles after any strobe, echoes db^KS a cycle later,
  // produces the tag 5 cycles after the final (core_start=0) data strobe.
  logic         ready_en = 1'b1;
  logic [127:0] cur_tag = '0;
  logic [2:0]   stall;
  logic [2:0]   tag_cnt;

  assign core_ready = ready_en && (stall == 3'd0) && (tag_cnt == 3'd0);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      stall <= '0; tag_cnt <= '0;
      core_valid_db_out <= 1'b0; core_valid_tag <= 1'b0; core_dout <= '0;
    end else begin
      core_valid_db_out <= 1'b0;
      core_valid_tag    <= 1'b0;
      if (stall != 3'd0) stall <= stall - 3'd1;
      if (core_valid_ad || core_valid_db_in) stall <= 3'd2;
      if (core_valid_db_in) begin
        core_valid_db_out <= 1'b1;
        core_dout         <= core_db ^ KS;
        if (!core_start) tag_cnt <= 3'd4;
      end
      if (tag_cnt != 3'd0) begin
        tag_cnt <= tag_cnt - 3'd1;
        if (tag_cnt == 3'd1) begin
          core_valid_tag <= 1'b1;
          core_dout      <= cur_tag;
        end
      end
    end
  end

  // Scoreboard
  typedef struct { bit is_ad; logic [127:0] data; bit start; } strb_t;
  typedef struct { logic [127:0] data; logic [4:0] bytes; bit last; } out_t;
  strb_t        sq[$];
  out_t         oq[$];
  logic [127:0] tq[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic exp_strobe(input bit is_ad, input logic [127:0] d, input bit st);
    strb_t e; e.is_ad = is_ad; e.data = d; e.start = st; sq.push_back(e);
  endtask

  task automatic exp_out(input logic [127:0] d, input logic [4:0] b, input bit l);
    out_t e; e.data = d; e.bytes = b; e.last = l; oq.push_back(e);
  endtask

  // Strobe monitor
  initial forever begin
    @(negedge clk);
    if (!rst && (core_valid_ad || core_valid_db_in)) begin
      if (sq.size() == 0) begin
        chk("strobe_unexpected", {core_valid_ad, core_valid_db_in}, 2'b00);
      end else begin
        strb_t e;
        e = sq.pop_front();
        chk("strobe_kind", {core_valid_ad, core_valid_db_in}, e.is_ad ? 2'b10 : 2'b01);
        chk(e.is_ad ? "core_ad" : "core_db", e.is_ad ? core_ad : core_db, e.data);
        chk("strobe_core_start", core_start, e.start);
      end
    end
  end

  // Output monitor
  initial forever begin
    @(negedge clk);
    if (!rst && m_valid) begin
      if (oq.size() == 0) begin
        chk("m_valid_unexpected", m_valid, 1'b0);
      end else begin
        out_t e;
        e = oq.pop_front();
        chk("m_data", m_data, e.data);
        chk("m_bytes", m_bytes, e.bytes);
        chk("m_last", m_last, e.last);
      end
    end
    if (!rst && tag_valid) begin
      if (tq.size() == 0) chk("tag_valid_unexpected", tag_valid, 1'b0);
      else chk("tag", tag, tq.pop_front());
    end
  end

  task automatic start_msg();
    @(posedge clk); #1 msg_start = 1'b1;
    @(posedge clk); #1 msg_start = 1'b0;
  endtask

  task automatic send(input bit is_ad, input logic [127:0] d, input logic [4:0] n, input bit l);
    int cnt;
    s_valid = 1'b1; s_is_ad = is_ad; s_data = d; s_bytes = n; s_last = l;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (s_ready) break;
      cnt++;
      if (cnt > 100) begin
        chk("s_ready_wait", 1'b0, 1'b1);
        break;
      end
    end
    @(posedge clk); #1;
    s_valid = 1'b0; s_data = '0; s_bytes = '0; s_is_ad = 1'b0; s_last = 1'b0;
  endtask

  task automatic finish_msg(input string nm);
    int cnt;
    cnt = 0;
    while (busy && cnt < 100) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk({nm, "_busy_drop"}, busy, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk({nm, "_strobes_left"}, sq.size(), 0);
    chk({nm, "_outputs_left"}, oq.size(), 0);
    chk({nm, "_tags_left"}, tq.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cnt;
    // Reset state
    #12;
    chk("rst_s_ready", s_ready, 1'b0);
    chk("rst_core_start", core_start, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_tag", tag, '0);
    chk("rst_errs", {err_proto, err_timeout}, 2'b00);
    chk("rst_strobes", {core_valid_ad, core_valid_db_in}, 2'b00);
    @(posedge clk); #1 rst = 1'b0;

    // 1: AD 16B+5B, PT 20B
    cur_tag = 128'h11111111_22222222_33333333_44444444;
    tq.push_back(128'h11111111_22222222_33333333_44444444);
    start_msg();
    chk("t1_core_start_rise", core_start, 1'b1);
    chk("t1_busy", busy, 1'b1);
    exp_strobe(1, 128'h0F0E0D0C_0B0A0908_07060504_03020100, 1);
    send(1, 128'h0F0E0D0C_0B0A0908_07060504_03020100, 5'd16, 0);
    exp_strobe(1, 128'h00000000_00000000_00000114_13121110, 1);
    send(1, 128'hEEEEEEEE_EEEEEEEE_EEEEEE14_13121110, 5'd5, 1);
    exp_strobe(0, 128'h2F2E2D2C_2B2A2928_27262524_23222120, 1);
    exp_out(128'hAFAEADAC_ABAAA9A8_A7A6A5A4_A3A2A1A0, 5'd16, 0);
    send(0, 128'h2F2E2D2C_2B2A2928_27262524_23222120, 5'd16, 0);
    exp_strobe(0, 128'h00000000_00000000_00000001_33323130, 0);
    exp_out(128'h00000000_00000000_00000000_B3B2B1B0, 5'd4, 1);
    send(0, 128'hDDDDDDDD_DDDDDDDD_DDDDDDDD_33323130, 5'd4, 1);
    finish_msg("t1");
    chk("t1_err_proto", err_proto, 1'b0);

    // 2: no AD, empty PT
    cur_tag = 128'hA5A5A5A5_5A5A5A5A_01234567_89ABCDEF;
    tq.push_back(128'hA5A5A5A5_5A5A5A5A_01234567_89ABCDEF);
    start_msg();
    exp_strobe(0, 128'h00000000_00000000_00000000_00000001, 0);
    exp_out(128'h0, 5'd0, 1);
    send(0, {16{8'hCC}}, 5'd0, 1);
    finish_msg("t2");

    // 3: AD exactly 16B, PT 32B
    cur_tag = 128'hDEADBEEF_00000000_CAFEF00D_00000003;
    tq.push_back(128'hDEADBEEF_00000000_CAFEF00D_00000003);
    start_msg();
    exp_strobe(1, 128'h4F4E4D4C_4B4A4948_47464544_43424140, 1);
    exp_strobe(1, 128'h00000000_00000000_00000000_00000001, 1);
    send(1, 128'h4F4E4D4C_4B4A4948_47464544_43424140, 5'd16, 1);
    exp_strobe(0, 128'h5F5E5D5C_5B5A5958_57565554_53525150, 1);
    exp_out(128'hDFDEDDDC_DBDAD9D8_D7D6D5D4_D3D2D1D0, 5'd16, 0);
    send(0, 128'h5F5E5D5C_5B5A5958_57565554_53525150, 5'd16, 0);
    exp_strobe(0, 128'h6F6E6D6C_6B6A6968_67666564_63626160, 1);
    exp_out(128'hEFEEEDEC_EBEAE9E8_E7E6E5E4_E3E2E1E0, 5'd16, 1);
    exp_strobe(0, 128'h00000000_00000000_00000000_00000001, 0);
    send(0, 128'h6F6E6D6C_6B6A6968_67666564_63626160, 5'd16, 1);
    finish_msg("t3");

    // 6: non-last short data block
    cur_tag = 128'h66666666_66666666_66666666_66666666;
    tq.push_back(128'h66666666_66666666_66666666_66666666);
    start_msg();
    exp_strobe(0, 128'h00000000_00000000_01060504_03020100, 0);
    exp_out(128'h00000000_00000000_00868584_83828180, 5'd7, 0);
    send(0, 128'hBBBBBBBB_BBBBBBBB_BB060504_03020100, 5'd7, 0);
    chk("t6_err_proto", err_proto, 1'b1);
    chk("t6_s_ready", s_ready, 1'b0);
    chk("t6_core_start", core_start, 1'b0);
    repeat (3) @(posedge clk);
    #1 chk("t6_s_ready_wait_tag", s_ready, 1'b0);
    finish_msg("t6");
    chk("t6_err_proto_sticky", err_proto, 1'b1);

    // 4: timeout with core_ready held low
    ready_en = 1'b0;
    start_msg();
    chk("t4_core_start_high", core_start, 1'b1);
    chk("t4_err_proto_cleared", err_proto, 1'b0);
    cnt = 0;
    while (!err_timeout && cnt < TMO + 10) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk("t4_err_timeout", err_timeout, 1'b1);
    chk("t4_core_start", core_start, 1'b0);
    chk("t4_busy", busy, 1'b0);
    ready_en = 1'b1;
    start_msg();
    chk("t4_err_timeout_cleared", err_timeout, 1'b0);
    chk("t4_busy_again", busy, 1'b1);

    // 5: reset during FEED, then a 1-block message
    repeat (2) @(posedge clk);
    #1 chk("t5_in_feed", s_ready, 1'b1);
    rst = 1'b1;
    #1;
    chk("t5_rst_s_ready", s_ready, 1'b0);
    chk("t5_rst_core_start", core_start, 1'b0);
    chk("t5_rst_busy", busy, 1'b0);
    chk("t5_rst_tag", tag, '0);
    chk("t5_rst_m", {m_valid, m_data, m_bytes, m_last, tag_valid}, '0);
    chk("t5_rst_errs", {err_proto, err_timeout}, 2'b00);
    @(posedge clk); #1 rst = 1'b0;
    cur_tag = 128'h55555555_AAAAAAAA_55555555_AAAAAAAA;
    tq.push_back(128'h55555555_AAAAAAAA_55555555_AAAAAAAA);
    start_msg();
    chk("t5_busy", busy, 1'b1);
    exp_strobe(0, 128'h00000000_00000000_00000000_01030201, 0);
    exp_out(128'h00000000_00000000_00000000_00838281, 5'd3, 1);
    send(0, 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FF030201, 5'd3, 1);
    finish_msg("t5");
    chk("t5_tag_hold", tag, 128'h55555555_AAAAAAAA_55555555_AAAAAAAA);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
